// File: rtl/jtframe_pll_rstgen.sv
// jtframe_pll_rstgen: reset sequencer and clock-enable generator behind the PLL.
// Waits for a stable PLL lock, releases the SDRAM controller and then the game
// core, and after release produces the clk/8, clk/16, clk/32 and fractional
// clock enables.
//
// Ports:
//   rst             in  async active-high reset
//   clk             in  fast system clock (PLL output)
//   pll_locked      in  PLL lock flag, asynchronous
//   sdram_init_done in  SDRAM controller finished its init sequence
//   soft_rst        in  single-cycle game-reset request
//   rst_sdram       out reset to the SDRAM controller
//   rst_game        out reset to the game core
//   cen12/cen6/cen3 out clock enables at clk/8, clk/16, clk/32
//   cenfrac         out fractional enable at clk*FRAC_N/FRAC_M
//   st              out current state (debug)
//
// Configuration macro: JTFRAME_RELOCK_EN
//   defined   - loss of lock after HOLD returns to WAIT_LOCK
//   undefined - lock is only watched during HOLD
module jtframe_pll_rstgen #(
    parameter int unsigned HOLD_W   = 8,
    parameter int unsigned SOFT_LEN = 16,
    parameter int unsigned FRAC_W   = 10,
    parameter int unsigned FRAC_N   = 1,
    parameter int unsigned FRAC_M   = 8
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       pll_locked,
    input  logic       sdram_init_done,
    input  logic       soft_rst,
    output logic       rst_sdram,
    output logic       rst_game,
    output logic       cen12,
    output logic       cen6,
    output logic       cen3,
    output logic       cenfrac,
    output logic [2:0] st
);

    localparam int unsigned SOFT_W = 8;
    localparam int unsigned DIV_W  = 5;
    localparam int unsigned SUM_W  = FRAC_W + 1;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD      = 3'd1,
        ST_SDRAM     = 3'd2,
        ST_RUN       = 3'd3,
        ST_SOFT      = 3'd4
    } state_t;

    state_t              st_q, st_d;
    logic [1:0]          sync_q, sync_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SOFT_W-1:0]   soft_cnt_q, soft_cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [FRAC_W-1:0]   acc_q, acc_d;
    logic                rst_sdram_q, rst_sdram_d;
    logic                rst_game_q, rst_game_d;
    logic                cen12_q, cen12_d;
    logic                cen6_q, cen6_d;
    logic                cen3_q, cen3_d;
    logic                cenfrac_q, cenfrac_d;

    logic                lk;
    logic                en;
    logic [SUM_W-1:0]    sum;
    logic                frac_hit;

    assign lk = sync_q[1];

    // State register and all output/datapath flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= ST_WAIT_LOCK;
            sync_q      <= '0;
            hold_cnt_q  <= '0;
            soft_cnt_q  <= '0;
            div_q       <= '0;
            acc_q       <= '0;
            rst_sdram_q <= 1'b1;
            rst_game_q  <= 1'b1;
            cen12_q     <= 1'b0;
            cen6_q      <= 1'b0;
            cen3_q      <= 1'b0;
            cenfrac_q   <= 1'b0;
        end else begin
            st_q        <= st_d;
            sync_q      <= sync_d;
            hold_cnt_q  <= hold_cnt_d;
            soft_cnt_q  <= soft_cnt_d;
            div_q       <= div_d;
            acc_q       <= acc_d;
            rst_sdram_q <= rst_sdram_d;
            rst_game_q  <= rst_game_d;
            cen12_q     <= cen12_d;
            cen6_q      <= cen6_d;
            cen3_q      <= cen3_d;
            cenfrac_q   <= cenfrac_d;
        end
    end

    // Next-state, counters and enables
    always_comb begin
        st_d       = st_q;
        hold_cnt_d = hold_cnt_q;
        soft_cnt_d = soft_cnt_q;
        sync_d     = {sync_q[0], pll_locked};

        case (st_q)
            ST_WAIT_LOCK: begin
                hold_cnt_d = '0;
                if (lk) begin
                    st_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!lk) begin
                    st_d = ST_WAIT_LOCK;
                end else if (&hold_cnt_q) begin
                    st_d = ST_SDRAM;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_SDRAM: begin
                if (sdram_init_done) begin
                    st_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (soft_rst) begin
                    st_d       = ST_SOFT;
                    soft_cnt_d = SOFT_W'(SOFT_LEN - 1);
                end
            end
            ST_SOFT: begin
                // soft_rst is deliberately not looked at here
                if (soft_cnt_q == '0) begin
                    st_d = ST_RUN;
                end else begin
                    soft_cnt_d = soft_cnt_q - SOFT_W'(1);
                end
            end
            default: begin
                st_d = ST_WAIT_LOCK;
            end
        endcase

`ifdef JTFRAME_RELOCK_EN
        // Lock lost after the hold window: restart the whole sequence
        if (!lk && (st_q == ST_SDRAM || st_q == ST_RUN || st_q == ST_SOFT)) begin
            st_d = ST_WAIT_LOCK;
        end
`endif

        rst_sdram_d = (st_d == ST_WAIT_LOCK) || (st_d == ST_HOLD);
        rst_game_d  = (st_d != ST_RUN);

        // Enables are also masked by the next reset value so they drop on
        // the same edge the SDRAM reset reasserts.
        en = !rst_sdram_q && !rst_sdram_d;

        div_d = rst_sdram_q ? '0 : div_q + DIV_W'(1);

        sum      = SUM_W'(acc_q) + SUM_W'(FRAC_N);
        frac_hit = (sum >= SUM_W'(FRAC_M));
        if (rst_sdram_q) begin
            acc_d = '0;
        end else if (frac_hit) begin
            acc_d = FRAC_W'(sum - SUM_W'(FRAC_M));
        end else begin
            acc_d = FRAC_W'(sum);
        end

        cen12_d   = en && (div_q[2:0] == 3'd7);
        cen6_d    = en && (div_q[3:0] == 4'd15);
        cen3_d    = en && (div_q == 5'd31);
        cenfrac_d = en && frac_hit;
    end

    assign rst_sdram = rst_sdram_q;
    assign rst_game  = rst_game_q;
    assign cen12     = cen12_q;
    assign cen6      = cen6_q;
    assign cen3      = cen3_q;
    assign cenfrac   = cenfrac_q;
    assign st        = st_q;

endmodule

// File: tb/tb_jtframe_pll_rstgen.sv
module tb_jtframe_pll_rstgen;

    logic       rst;
    logic       clk;
    logic       pll_locked;
    logic       sdram_init_done;
    logic       soft_rst;
    logic       rst_sdram;
    logic       rst_game;
    logic       cen12;
    logic       cen6;
    logic       cen3;
    logic       cenfrac;
    logic [2:0] st;

    int total;
    int bad;

    jtframe_pll_rstgen #(
        .HOLD_W   (4),
        .SOFT_LEN (16),
        .FRAC_W   (10),
        .FRAC_N   (3),
        .FRAC_M   (8)
    ) dut (
        .rst             (rst),
        .clk             (clk),
        .pll_locked      (pll_locked),
        .sdram_init_done (sdram_init_done),
        .soft_rst        (soft_rst),
        .rst_sdram       (rst_sdram),
        .rst_game        (rst_game),
        .cen12           (cen12),
        .cen6            (cen6),
        .cen3            (cen3),
        .cenfrac         (cenfrac),
        .st              (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Power-up vector: state after <cyc> clock edges since rst release
    typedef struct {
        int   cyc;
        int   exp_st;
        logic exp_rsd;
        logic exp_rg;
        logic exp_cen12;
        logic exp_cenfrac;
        logic set_init;
    } vec_t;

    vec_t vecs[12];

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int cur;
        int early;
        int n12, n6, n3, nfr, consec;
        logic prev_fr;
        int rg_hi, rsd_hi, last12, bad_period;
        int waited;

        total = 0;
        bad = 0;
        rst = 1'b1;
        pll_locked = 1'b1;
        sdram_init_done = 1'b0;
        soft_rst = 1'b0;

        //            cyc st rsd rg c12 cfr init
        vecs[0]  = '{  0, 0, 1, 1, 0, 0, 0};
        vecs[1]  = '{  2, 0, 1, 1, 0, 0, 0};
        vecs[2]  = '{  3, 1, 1, 1, 0, 0, 0};
        vecs[3]  = '{ 18, 1, 1, 1, 0, 0, 0};
        vecs[4]  = '{ 19, 2, 0, 1, 0, 0, 0};
        vecs[5]  = '{ 21, 2, 0, 1, 0, 0, 0};
        vecs[6]  = '{ 22, 2, 0, 1, 0, 1, 0};
        vecs[7]  = '{ 26, 2, 0, 1, 0, 0, 0};
        vecs[8]  = '{ 27, 2, 0, 1, 1, 1, 0};
        vecs[9]  = '{ 30, 2, 0, 1, 0, 1, 1};
        vecs[10] = '{ 31, 3, 0, 0, 0, 0, 0};
        vecs[11] = '{ 35, 3, 0, 0, 1, 1, 0};

        // Lock glitch during HOLD: hold restarts from scratch after relock
        do_reset();
        chk("glitch_rst_st", int'(st), 0);
        early = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            #1;
            if (c == 10) pll_locked = 1'b0;
            if (c == 13) pll_locked = 1'b1;
            if (c == 12) chk("glitch_st_c12", int'(st), 1);
            if (c == 13) chk("glitch_st_c13", int'(st), 0);
            if (c == 16) chk("glitch_st_c16", int'(st), 1);
            if (c < 32 && rst_sdram == 1'b0) early++;
        end
        chk("glitch_early_release", early, 0);
        chk("glitch_st_c32", int'(st), 2);
        chk("glitch_rsd_c32", int'(rst_sdram), 0);

        // Power-up sequence from the vector table
        do_reset();
        cur = 0;
        for (int i = 0; i < 12; i++) begin
            while (cur < vecs[i].cyc) begin
                @(negedge clk);
                #1;
                cur++;
            end
            chk($sformatf("pu_st_c%0d", cur), int'(st), vecs[i].exp_st);
            chk($sformatf("pu_rsd_c%0d", cur), int'(rst_sdram), int'(vecs[i].exp_rsd));
            chk($sformatf("pu_rg_c%0d", cur), int'(rst_game), int'(vecs[i].exp_rg));
            chk($sformatf("pu_cen12_c%0d", cur), int'(cen12), int'(vecs[i].exp_cen12));
            chk($sformatf("pu_cenfrac_c%0d", cur), int'(cenfrac), int'(vecs[i].exp_cenfrac));
            if (vecs[i].set_init) sdram_init_done = 1'b1;
        end

        // Enable rates over 800 cycles in RUN
        n12 = 0; n6 = 0; n3 = 0; nfr = 0; consec = 0; prev_fr = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            n12 += int'(cen12);
            n6  += int'(cen6);
            n3  += int'(cen3);
            nfr += int'(cenfrac);
            if (cenfrac && prev_fr) consec++;
            prev_fr = cenfrac;
        end
        chk("en_cen12", n12, 100);
        chk("en_cen6", n6, 50);
        chk("en_cen3", n3, 25);
        chk("en_cenfrac", nfr, 300);
        chk("en_cenfrac_consec", consec, 0);

        // Soft reset, with a second pulse arriving during SOFT
        soft_rst = 1'b1;
        rg_hi = 0; rsd_hi = 0; last12 = -1; bad_period = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            soft_rst = (c == 5);
            if (c == 0) chk("soft_rg_first", int'(rst_game), 1);
            rg_hi  += int'(rst_game);
            rsd_hi += int'(rst_sdram);
            if (cen12) begin
                if (last12 >= 0 && c - last12 != 8) bad_period++;
                last12 = c;
            end
        end
        soft_rst = 1'b0;
        chk("soft_rg_len", rg_hi, 16);
        chk("soft_rsd_low", rsd_hi, 0);
        chk("soft_cen12_period", bad_period, 0);
        chk("soft_st_back", int'(st), 3);

        // Loss of lock in RUN
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
`ifdef JTFRAME_RELOCK_EN
        chk("relock_rsd", int'(rst_sdram), 1);
        chk("relock_rg", int'(rst_game), 1);
        chk("relock_st", int'(st), 0);
        chk("relock_cens", int'({cen12, cen6, cen3, cenfrac}), 0);
`else
        chk("relock_rsd", int'(rst_sdram), 0);
        chk("relock_rg", int'(rst_game), 0);
        chk("relock_st", int'(st), 3);
`endif
        n12 = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n12 += int'(cen12);
        end
`ifdef JTFRAME_RELOCK_EN
        chk("relock_cen12_stopped", n12, 0);
`else
        chk("relock_cen12_running", n12, 2);
`endif
        pll_locked = 1'b1;

        // Back to RUN (bounded wait)
        waited = 0;
        while (st != 3'd3 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("rerun_reached", int'(st), 3);

        // Async reset mid-SOFT, between clock edges
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("async_pre_st", int'(st), 4);
        #2;
        rst = 1'b1;
        #1;
        chk("async_st", int'(st), 0);
        chk("async_rsd", int'(rst_sdram), 1);
        chk("async_rg", int'(rst_game), 1);
        chk("async_cens", int'({cen12, cen6, cen3, cenfrac}), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
